// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: opcode and FSM state types shared by the multi-cycle ALU.
// The optional divider is selected with the ALU_MC_DIV_EN macro.
package alu_mc_pkg;

    localparam int ALU_SEL_W = 4;

    typedef enum logic [ALU_SEL_W-1:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_MUL  = 4'd2,
        OP_DIV  = 4'd3,
        OP_SHL  = 4'd4,
        OP_SHR  = 4'd5,
        OP_ROTL = 4'd6,
        OP_ROTR = 4'd7,
        OP_AND  = 4'd8,
        OP_OR   = 4'd9,
        OP_XOR  = 4'd10,
        OP_NOR  = 4'd11,
        OP_NAND = 4'd12,
        OP_XNOR = 4'd13,
        OP_GT   = 4'd14,
        OP_EQ   = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_mc_iter.sv
// alu_mc_iter: iterative unsigned shift-add multiplier and, when
// ALU_MC_DIV_EN is defined, a restoring divider. One bit per cycle.
// done_o is asserted combinationally in the cycle whose clock edge performs
// the last iteration; result_o/hi_nonzero_o then carry that final value so the
// parent can capture it on the same edge.
module alu_mc_iter
    import alu_mc_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int ITER_CYCLES = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  alu_op_e          op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             hi_nonzero_o
);

    localparam int CNT_W = $clog2(ITER_CYCLES) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER_CYCLES - 1);

    logic               busy_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_d;
    logic               load;

`ifdef ALU_MC_DIV_EN
    logic               div_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   dvsr_q;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   rem_d;
    logic [WIDTH-1:0]   quo_d;

    assign load = start_i && (op_i == OP_MUL || op_i == OP_DIV);

    // Restoring division step: shift the next dividend bit into the
    // remainder and keep the subtraction only when it does not go negative.
    always_comb begin
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        trial  = rem_sh - {1'b0, dvsr_q};
        quo_d  = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        rem_d  = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
    end
`else
    assign load = start_i && (op_i == OP_MUL);
`endif

    // Shift-add step: accumulate the shifted multiplicand when the current
    // multiplier bit is set.
    always_comb begin
        acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    assign done_o = busy_q && (cnt_q == LAST);

`ifdef ALU_MC_DIV_EN
    assign result_o     = div_q ? quo_d : acc_d[WIDTH-1:0];
    assign hi_nonzero_o = !div_q && (|acc_d[2*WIDTH-1:WIDTH]);
`else
    assign result_o     = acc_d[WIDTH-1:0];
    assign hi_nonzero_o = |acc_d[2*WIDTH-1:WIDTH];
`endif

    // Iteration registers: load operands on start, then step once per cycle
    // until the last iteration; reset aborts any iteration in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
`ifdef ALU_MC_DIV_EN
            div_q    <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
`endif
        end else if (load) begin
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a_i};
            mplier_q <= b_i;
`ifdef ALU_MC_DIV_EN
            div_q    <= (op_i == OP_DIV);
            rem_q    <= '0;
            quo_q    <= a_i;
            dvsr_q   <= b_i;
`endif
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
`ifdef ALU_MC_DIV_EN
            rem_q    <= rem_d;
            quo_q    <= quo_d;
`endif
            cnt_q    <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshakes on both sides.
// Single-cycle ops complete one cycle after accept; mul (and div when
// ALU_MC_DIV_EN is defined) run through alu_mc_iter for WIDTH cycles.
// Without ALU_MC_DIV_EN, op 3 completes immediately with err=1.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [ALU_SEL_W-1:0] alu_sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     alu_out,
    output logic                 carry_out,
    output logic                 zero,
    output logic                 err
);

    localparam int ITER_CYCLES = WIDTH;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic             err_q, err_d;

    alu_op_e          op_in;
    logic             accept;
    logic             iter_start;
    logic             iter_done;
    logic [WIDTH-1:0] iter_res;
    logic             iter_hi;

    logic [WIDTH:0]   sum_w;
    logic [WIDTH-1:0] sc_res;
    logic             sc_carry;
    logic             sc_err;

    assign op_in     = alu_op_e'(alu_sel);
    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign alu_out   = res_q;
    assign carry_out = carry_q;
    assign err       = err_q;
    assign zero      = out_valid && (res_q == '0);

`ifdef ALU_MC_DIV_EN
    assign iter_start = accept && (op_in == OP_MUL || (op_in == OP_DIV && B != '0));
`else
    assign iter_start = accept && (op_in == OP_MUL);
`endif

    alu_mc_iter #(
        .WIDTH       (WIDTH),
        .ITER_CYCLES (ITER_CYCLES)
    ) u_iter (
        .clk          (clk),
        .rst          (rst),
        .start_i      (iter_start),
        .op_i         (op_in),
        .a_i          (A),
        .b_i          (B),
        .done_o       (iter_done),
        .result_o     (iter_res),
        .hi_nonzero_o (iter_hi)
    );

    // Single-cycle result computed straight from the request operands.
    always_comb begin
        sum_w    = {1'b0, A} + {1'b0, B};
        sc_res   = '0;
        sc_carry = 1'b0;
        sc_err   = 1'b0;
        case (op_in)
            OP_ADD: begin
                sc_res   = sum_w[WIDTH-1:0];
                sc_carry = sum_w[WIDTH];
            end
            OP_SUB: begin
                sc_res   = A - B;
                sc_carry = (A < B);
            end
            OP_MUL: begin
                sc_res = '0;
            end
            OP_DIV: begin
`ifdef ALU_MC_DIV_EN
                sc_res = '1;
`else
                sc_res = '0;
`endif
                sc_err = 1'b1;
            end
            OP_SHL: begin
                sc_res   = {A[WIDTH-2:0], 1'b0};
                sc_carry = A[WIDTH-1];
            end
            OP_SHR: begin
                sc_res   = {1'b0, A[WIDTH-1:1]};
                sc_carry = A[0];
            end
            OP_ROTL: sc_res = {A[WIDTH-2:0], A[WIDTH-1]};
            OP_ROTR: sc_res = {A[0], A[WIDTH-1:1]};
            OP_AND:  sc_res = A & B;
            OP_OR:   sc_res = A | B;
            OP_XOR:  sc_res = A ^ B;
            OP_NOR:  sc_res = ~(A | B);
            OP_NAND: sc_res = ~(A & B);
            OP_XNOR: sc_res = ~(A ^ B);
            OP_GT:   sc_res = {{(WIDTH-1){1'b0}}, (A > B)};
            OP_EQ:   sc_res = {{(WIDTH-1){1'b0}}, (A == B)};
        endcase
    end

    // Next state and result capture: accept from IDLE or a draining DONE,
    // capture the iterative result on its final edge, return to IDLE on drain.
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        carry_d = carry_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    if (iter_start) begin
                        state_d = ST_BUSY;
                    end else begin
                        state_d = ST_DONE;
                        res_d   = sc_res;
                        carry_d = sc_carry;
                        err_d   = sc_err;
                    end
                end else if ((state_q == ST_DONE) && out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (iter_done) begin
                    state_d = ST_DONE;
                    res_d   = iter_res;
                    carry_d = iter_hi;
                    err_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            res_q   <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed and randomized checks of alu_mc (WIDTH=8) against an
// arithmetic reference model. Honors ALU_MC_DIV_EN the same way as the RTL.
module tb_alu_mc;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] A;
    logic [7:0] B;
    logic [3:0] alu_sel;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] alu_out;
    logic       carry_out;
    logic       zero;
    logic       err;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .alu_sel   (alu_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_out   (alu_out),
        .carry_out (carry_out),
        .zero      (zero),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model built from the opcode definitions with integer math.
    task automatic model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                         output logic [7:0] r, output logic c, output logic e, output int lat);
        int ai;
        int bi;
        int t;
        ai  = int'(a);
        bi  = int'(b);
        t   = 0;
        r   = 8'h00;
        c   = 1'b0;
        e   = 1'b0;
        lat = 1;
        case (sel)
            4'd0: begin t = ai + bi; r = 8'(t); c = (t > 255); end
            4'd1: begin t = ai - bi; r = 8'(t); c = (ai < bi); end
            4'd2: begin t = ai * bi; r = 8'(t); c = (t > 255); lat = W + 1; end
            4'd3: begin
`ifdef ALU_MC_DIV_EN
                if (bi == 0) begin
                    r = 8'hFF;
                    e = 1'b1;
                end else begin
                    r   = 8'(ai / bi);
                    lat = W + 1;
                end
`else
                e = 1'b1;
`endif
            end
            4'd4: begin r = 8'(ai * 2); c = (ai >= 128); end
            4'd5: begin r = 8'(ai / 2); c = ((ai % 2) == 1); end
            4'd6: r = 8'(ai * 2 + ai / 128);
            4'd7: r = 8'(ai / 2 + (ai % 2) * 128);
            4'd8: r = a & b;
            4'd9: r = a | b;
            4'd10: r = a ^ b;
            4'd11: r = ~(a | b);
            4'd12: r = ~(a & b);
            4'd13: r = ~(a ^ b);
            4'd14: r = (ai > bi) ? 8'd1 : 8'd0;
            default: r = (ai == bi) ? 8'd1 : 8'd0;
        endcase
    endtask

    // One complete transaction: issue, wait for the result, hold, drain.
    // Called at a negedge with the DUT idle.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                          input int hold);
        logic [7:0] er;
        logic       ec;
        logic       ee;
        int         elat;
        int         lat;
        model(a, b, sel, er, ec, ee, elat);
        chk("pre_in_ready", 32'(in_ready), 1);
        A         = a;
        B         = b;
        alu_sel   = sel;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        A        = 8'($urandom);
        B        = 8'($urandom);
        alu_sel  = 4'($urandom);
        lat      = 1;
        while (!out_valid && lat < 40) begin
            chk("busy_in_ready", 32'(in_ready), 0);
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'(elat));
        chk("alu_out", 32'(alu_out), 32'(er));
        chk("carry_out", 32'(carry_out), 32'(ec));
        chk("zero", 32'(zero), 32'(er == 8'h00));
        chk("err", 32'(err), 32'(ee));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_alu_out", 32'(alu_out), 32'(er));
            chk("hold_carry", 32'(carry_out), 32'(ec));
            chk("hold_err", 32'(err), 32'(ee));
        end
        $display("[TB] op=%0d A=%02h B=%02h -> out=%02h c=%b z=%b err=%b lat=%0d",
                 sel, a, b, alu_out, carry_out, zero, err, lat);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("drain_out_valid", 32'(out_valid), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] er;
        logic       ec;
        logic       ee;
        int         elat;
        int         seen;

        // Reset state.
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = 8'h00;
        B         = 8'h00;
        alu_sel   = 4'd0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_alu_out", 32'(alu_out), 0);
        chk("rst_carry", 32'(carry_out), 0);
        chk("rst_zero", 32'(zero), 0);
        chk("rst_err", 32'(err), 0);
        rst = 1'b0;
        @(negedge clk);
        $display("[TB] reset released");

        // Directed corner cases.
        run_op(8'hFF, 8'h01, 4'd0, 0);
        run_op(8'h05, 8'h04, 4'd1, 0);
        run_op(8'h04, 8'h05, 4'd1, 0);
        run_op(8'h20, 8'h10, 4'd2, 0);
        run_op(8'h64, 8'h07, 4'd3, 0);
        run_op(8'h64, 8'h00, 4'd3, 0);
        run_op(8'h81, 8'h00, 4'd4, 1);
        run_op(8'h81, 8'h00, 4'd5, 0);
        run_op(8'hFF, 8'hFF, 4'd2, 0);

        // Stall for 5 cycles in DONE, then drain and accept in the same cycle.
        model(8'h3C, 8'h0F, 4'd10, er, ec, ee, elat);
        A        = 8'h3C;
        B        = 8'h0F;
        alu_sel  = 4'd10;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("stall_valid", 32'(out_valid), 1);
        repeat (5) begin
            @(negedge clk);
            chk("stall_hold_valid", 32'(out_valid), 1);
            chk("stall_hold_out", 32'(alu_out), 32'(er));
            chk("stall_hold_in_ready", 32'(in_ready), 0);
        end
        A         = 8'h12;
        B         = 8'h34;
        alu_sel   = 4'd0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("b2b_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("b2b_valid", 32'(out_valid), 1);
        chk("b2b_out", 32'(alu_out), 32'h46);
        chk("b2b_carry", 32'(carry_out), 0);
        $display("[TB] back-to-back A=12 B=34 add -> out=%02h", alu_out);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("b2b_drain", 32'(out_valid), 0);

        // Reset in the middle of a multiply aborts it.
        A        = 8'h20;
        B        = 8'h10;
        alu_sel  = 4'd2;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_in_ready", 32'(in_ready), 1);
        chk("abort_out_valid", 32'(out_valid), 0);
        chk("abort_alu_out", 32'(alu_out), 0);
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("abort_no_result", 32'(seen), 0);
        $display("[TB] mul aborted by reset, spurious results=%0d", seen);

        // Randomized transactions.
        for (int n = 0; n < 80; n++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom);
            rb = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            run_op(ra, rb, 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width (min 4).
REQ-002 SHALL have parameter ITER_CYCLES, default WIDTH, iterations per mul/div (read-only, derived; not overridable).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operation request.
REQ-006 SHALL have port in_ready  output  1  request accepted when in_valid && in_ready.
REQ-007 SHALL have ports A, B  input  WIDTH  operands; alu_sel  input  4  opcode.
REQ-008 SHALL have port out_valid  output  1  result available.
REQ-009 SHALL have port out_ready  input  1  consumer takes result when out_valid && out_ready.
REQ-010 SHALL have ports alu_out  output  WIDTH  result; carry_out  output  1  carry/borrow/overflow; zero  output  1  alu_out==0; err  output  1  illegal/div-by-zero.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-012 in_ready SHALL be 1 in IDLE, and in DONE when out_ready=1 (back-to-back accept); 0 in BUSY.
REQ-013 On accept, SHALL register A, B, alu_sel; operands changing afterwards have no effect.
REQ-014 Single-cycle ops: out_valid=1 on the cycle after accept (latency 1), state DONE.
REQ-015 Opcodes: 0 add, 1 sub, 2 mul, 3 div, 4 shl by 1, 5 shr by 1, 6 rotl by 1, 7 rotr by 1, 8 and, 9 or, 10 xor, 11 nor, 12 nand, 13 xnor, 14 A>B unsigned, 15 A==B.
REQ-016 Add: carry_out=carry from bit WIDTH-1; sub: carry_out=1 iff A<B (borrow), result modulo 2^WIDTH.
REQ-017 shl/shr: carry_out=bit shifted out; rotates, logic ops: carry_out=0.
REQ-018 Compares: alu_out=1 or 0 zero-extended, carry_out=0.
REQ-019 Mul (op 2): iterative shift-add, unsigned, BUSY for exactly ITER_CYCLES cycles, out_valid at accept+ITER_CYCLES+1; alu_out=low WIDTH bits; carry_out=1 iff high WIDTH bits nonzero.
REQ-020 Div (op 3): restoring, unsigned, same latency as mul; alu_out=quotient, carry_out=0.
REQ-021 Div with B=0: skips BUSY, latency 1, alu_out=all ones, carry_out=0, err=1.
REQ-022 err SHALL be 0 for every other completed op.
REQ-023 DONE SHALL hold alu_out, carry_out, zero, err stable while out_valid && !out_ready.
REQ-024 DONE with out_ready=1 and no new accept SHALL go to IDLE and drop out_valid next cycle.
REQ-025 zero SHALL be derived from the registered alu_out, valid only with out_valid.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE, in_ready=1 next cycle, out_valid=0, alu_out=0, carry_out=0, zero=0, err=0.
REQ-027 rst during BUSY SHALL abort the iteration; no result is produced.

Configuration
REQ-028 Macro ALU_MC_DIV_EN: defined, op 3 behaves per REQ-020/021.
REQ-029 Undefined: divider hardware absent; op 3 completes at latency 1 with alu_out=0, carry_out=0, err=1.

Structure
REQ-030 Package alu_mc_pkg SHALL hold opcode enum (OP_ADD..OP_EQ), FSM state enum, ALU_SEL_W=4.
REQ-031 Iterative mul/div datapath SHALL be sub-module alu_mc_iter (start, op, A, B -> done, result, hi_nonzero).

Verification (WIDTH=8)
REQ-032 A=0xFF, B=0x01, op 0 -> alu_out=0x00, carry_out=1, zero=1, latency 1.
REQ-033 A=0x05, B=0x04, op 1 -> 0x01, carry_out=0; A=0x04, B=0x05 -> 0xFF, carry_out=1.
REQ-034 A=0x20, B=0x10, op 2 -> alu_out=0x00, carry_out=1, out_valid 9 cycles after accept, in_ready=0 meanwhile.
REQ-035 A=0x64, B=0x07, op 3 -> 0x0E; B=0 -> 0xFF, err=1, latency 1 (with ALU_MC_DIV_EN).
REQ-036 out_ready held 0 for 5 cycles in DONE -> outputs stable; then out_ready=1 with in_valid=1 -> new op accepted same cycle.
REQ-037 rst asserted 3 cycles into mul -> out_valid never rises for it, in_ready=1 next cycle.
